mem_arbiter: RTL and testbench

- Shares one physical memory port between the instruction-fetch requester (i_mem_*) and the data-access requester (d_mem_*) of the pipelined LC-3b core.
- Sits between the cpu_datapath memory ports and the single pmem interface.
- Grants one requester at a time and latches that requester's command. The granted requester sees its resp pulse; the other sees no resp, which gives the pipeline its stall source.

---
 rtl/lc3b_types.sv | 38 +++
 rtl/mem_cmd_reg.sv | 26 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types: data/mask words, arbiter state, and the latched memory command.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } lc3b_arb_state;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_word      address;
    lc3b_word      wdata;
    lc3b_mem_wmask byte_enable;
  } lc3b_mem_cmd;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  function automatic lc3b_mem_cmd make_cmd(input logic          read,
                                           input logic          write,
                                           input lc3b_word      address,
                                           input lc3b_word      wdata,
                                           input lc3b_mem_wmask byte_enable);
    lc3b_mem_cmd c;
    c.read        = read;
    c.write       = write;
    c.address     = address;
    c.wdata       = wdata;
    c.byte_enable = byte_enable;
    return c;
  endfunction

endpackage

// File: rtl/mem_cmd_reg.sv
// Holds the granted memory command; load on grant, clear of read/write on completion,
// full clear on reset.
module mem_cmd_reg
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  lc3b_mem_cmd cmd_in,
  output lc3b_mem_cmd cmd
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd <= '0;
    end else if (load) begin
      cmd <= cmd_in;
    end else if (clear) begin
      // address/data are kept; only the command bits terminate the transfer
      cmd.read  <= 1'b0;
      cmd.write <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pmem port between instruction fetch and data access; 1-cycle arbitration.
// Data has fixed priority unless MEM_ARB_RR_EN is defined (alternating grant on contention).
module mem_arbiter
  import lc3b_types::*;
#(
  parameter  int DATA_W = 16,
  parameter  int ADDR_W = 16,
  localparam int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,

  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [DATA_W-1:0] d_mem_wdata,
  input  logic [MASK_W-1:0] d_mem_byte_enable,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  output logic [MASK_W-1:0] pmem_byte_enable,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  lc3b_arb_state state, next_state;
  lc3b_mem_cmd   cmd, cmd_in;
  logic          d_req, grant_d, load, clear;

  assign d_req = d_mem_read | d_mem_write;

`ifdef MEM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_I;
    end else if (load) begin
      last_grant <= grant_d;
    end
  end

  assign grant_d = d_req & (~i_mem_read | (last_grant == GRANT_I));
`else
  assign grant_d = d_req;
`endif

  // A simultaneous read+write from the data side is latched as a write.
  assign cmd_in = grant_d
    ? make_cmd(d_mem_read & ~d_mem_write, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable)
    : make_cmd(1'b1, 1'b0, i_mem_address, '0, '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    clear      = 1'b0;
    i_mem_resp = 1'b0;
    d_mem_resp = 1'b0;
    case (state)
      IDLE: begin
        if (d_req || i_mem_read) begin
          load       = 1'b1;
          next_state = grant_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          i_mem_resp = 1'b1;
          clear      = 1'b1;
          next_state = IDLE;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          d_mem_resp = 1'b1;
          clear      = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  mem_cmd_reg u_cmd_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .clear  (clear),
    .cmd_in (cmd_in),
    .cmd    (cmd)
  );

  // pmem is fed only from the command register: no path from requester inputs.
  assign pmem_read        = cmd.read;
  assign pmem_write       = cmd.write;
  assign pmem_address     = cmd.address;
  assign pmem_wdata       = cmd.wdata;
  assign pmem_byte_enable = cmd.byte_enable;

  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected pmem transfers and responses.
module tb_mem_arbiter;
  import lc3b_types::*;

  logic        clk;
  logic        rst;
  logic        i_mem_read;
  logic [15:0] i_mem_address;
  logic [15:0] i_mem_rdata;
  logic        i_mem_resp;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [15:0] d_mem_address;
  logic [15:0] d_mem_wdata;
  logic [1:0]  d_mem_byte_enable;
  logic [15:0] d_mem_rdata;
  logic        d_mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  mask;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  mem_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .i_mem_read        (i_mem_read),
    .i_mem_address     (i_mem_address),
    .i_mem_rdata       (i_mem_rdata),
    .i_mem_resp        (i_mem_resp),
    .d_mem_read        (d_mem_read),
    .d_mem_write       (d_mem_write),
    .d_mem_address     (d_mem_address),
    .d_mem_wdata       (d_mem_wdata),
    .d_mem_byte_enable (d_mem_byte_enable),
    .d_mem_rdata       (d_mem_rdata),
    .d_mem_resp        (d_mem_resp),
    .pmem_read         (pmem_read),
    .pmem_write        (pmem_write),
    .pmem_address      (pmem_address),
    .pmem_wdata        (pmem_wdata),
    .pmem_byte_enable  (pmem_byte_enable),
    .pmem_rdata        (pmem_rdata),
    .pmem_resp         (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // The bench never drives the illegal read+write combination.
  always @(posedge clk) begin
    assert (!(d_mem_read && d_mem_write))
      else $error("FAIL illegal_rw: d_mem_read and d_mem_write both high");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic push(input bit is_d, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [1:0] mask, input logic [15:0] rdata);
    exp_t e;
    e.is_d = is_d; e.wr = wr; e.addr = addr; e.wdata = wdata; e.mask = mask; e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Waits for the next pmem command, checks it against the scoreboard head, perturbs the
  // requester's address mid-transfer, then responds after lat cycles.
  task automatic serve(input int lat, input bit drop);
    exp_t        e;
    int          w;
    logic [15:0] orig;
    w = 0;
    while (!(pmem_read || pmem_write) && w < 20) begin
      tick();
      w++;
    end
    chk("cmd_start", {31'b0, pmem_read | pmem_write}, 32'd1);
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard: observed empty queue required pending entry");
      return;
    end
    e = sb.pop_front();
    chk("pmem_address", {16'b0, pmem_address}, {16'b0, e.addr});
    chk("pmem_read",    {31'b0, pmem_read},    {31'b0, ~e.wr});
    chk("pmem_write",   {31'b0, pmem_write},   {31'b0, e.wr});
    if (e.wr) begin
      chk("pmem_wdata",       {16'b0, pmem_wdata},       {16'b0, e.wdata});
      chk("pmem_byte_enable", {30'b0, pmem_byte_enable}, {30'b0, e.mask});
    end
    if (e.is_d) begin
      orig = d_mem_address; d_mem_address = orig ^ 16'h0100;
    end else begin
      orig = i_mem_address; i_mem_address = orig ^ 16'h0100;
    end
    repeat (lat - 1) begin
      tick();
      chk("addr_stable", {16'b0, pmem_address}, {16'b0, e.addr});
    end
    tick();
    if (e.is_d) d_mem_address = orig; else i_mem_address = orig;
    pmem_rdata = e.rdata;
    pmem_resp  = 1'b1;
    #1;
    chk("i_mem_resp", {31'b0, i_mem_resp}, {31'b0, ~e.is_d});
    chk("d_mem_resp", {31'b0, d_mem_resp}, {31'b0, e.is_d});
    chk(e.is_d ? "d_mem_rdata" : "i_mem_rdata",
        {16'b0, e.is_d ? d_mem_rdata : i_mem_rdata}, {16'b0, e.rdata});
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = 16'h0;
    if (drop) begin
      if (e.is_d) begin d_mem_read = 1'b0; d_mem_write = 1'b0; end
      else i_mem_read = 1'b0;
    end
    #1;
    chk("resp_single_pulse", {30'b0, i_mem_resp, d_mem_resp}, 32'd0);
    chk("idle_gap_cmd",      {30'b0, pmem_read, pmem_write},  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    i_mem_read = 1'b0; i_mem_address = 16'h0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_address = 16'h0;
    d_mem_wdata = 16'h0; d_mem_byte_enable = 2'b00;
    pmem_rdata = 16'h0; pmem_resp = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_pmem_rw",   {30'b0, pmem_read, pmem_write}, 32'd0);
    chk("rst_pmem_addr", {16'b0, pmem_address}, 32'd0);
    chk("rst_pmem_data", {14'b0, pmem_wdata, pmem_byte_enable}, 32'd0);
    chk("rst_resp",      {30'b0, i_mem_resp, d_mem_resp}, 32'd0);
    chk("rst_state",     {30'b0, dut.state}, {30'b0, IDLE});
    rst = 1'b0;
    tick();

    // single instruction read, 3-cycle memory
    i_mem_read = 1'b1; i_mem_address = 16'h0040;
    push(1'b0, 1'b0, 16'h0040, 16'h0, 2'b00, 16'h1234);
    tick();
    chk("i_read_cycle1",      {31'b0, pmem_read}, 32'd1);
    chk("i_read_addr_cycle1", {16'b0, pmem_address}, 32'h0040);
    serve(3, 1'b1);

    // contention: data write served first, then instruction read after one idle cycle
    i_mem_read = 1'b1; i_mem_address = 16'h0080;
    d_mem_write = 1'b1; d_mem_address = 16'h0100; d_mem_wdata = 16'hBEEF; d_mem_byte_enable = 2'b01;
    push(1'b1, 1'b1, 16'h0100, 16'hBEEF, 2'b01, 16'hAAAA);
    push(1'b0, 1'b0, 16'h0080, 16'h0, 2'b00, 16'h5678);
    serve(2, 1'b1);
    tick();
    chk("i_after_one_idle", {31'b0, pmem_read}, 32'd1);
    serve(2, 1'b1);

    // address change mid-transfer (0x0200 -> 0x0300 inside serve)
    d_mem_read = 1'b1; d_mem_address = 16'h0200;
    push(1'b1, 1'b0, 16'h0200, 16'h0, 2'b00, 16'h9ABC);
    serve(4, 1'b1);

    // reset during BUSY_I with a stale pmem_resp one cycle later
    i_mem_read = 1'b1; i_mem_address = 16'h0400;
    tick();
    chk("busy_i_before_rst", {31'b0, pmem_read}, 32'd1);
    rst = 1'b1; i_mem_read = 1'b0;
    tick();
    chk("rst_abort_read", {31'b0, pmem_read}, 32'd0);
    rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
    #1;
    chk("stale_resp_i",    {31'b0, i_mem_resp}, 32'd0);
    chk("stale_resp_d",    {31'b0, d_mem_resp}, 32'd0);
    chk("rst_abort_state", {30'b0, dut.state}, {30'b0, IDLE});
    tick();
    pmem_resp = 1'b0; pmem_rdata = 16'h0;
    #1;
    chk("rst_abort_no_cmd", {30'b0, pmem_read, pmem_write}, 32'd0);

    // both requests held for 4 transfers
    i_mem_read = 1'b1; i_mem_address = 16'h0500;
    d_mem_read = 1'b1; d_mem_address = 16'h0600;
`ifdef MEM_ARB_RR_EN
    push(1'b1, 1'b0, 16'h0600, 16'h0, 2'b00, 16'h1111);
    push(1'b0, 1'b0, 16'h0500, 16'h0, 2'b00, 16'h2222);
    push(1'b1, 1'b0, 16'h0600, 16'h0, 2'b00, 16'h3333);
    push(1'b0, 1'b0, 16'h0500, 16'h0, 2'b00, 16'h4444);
`else
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 16'h0600, 16'h0, 2'b00, 16'h1111 * (k + 1));
`endif
    for (int k = 0; k < 4; k++) serve(2, 1'b0);
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    tick();
    chk("held_done_no_cmd", {30'b0, pmem_read, pmem_write}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);

    // idle with a single pmem_resp glitch
    for (int k = 0; k < 10; k++) begin
      pmem_resp = (k == 4);
      pmem_rdata = 16'hF00D;
      #1;
      chk("idle_glitch_resp", {30'b0, i_mem_resp, d_mem_resp}, 32'd0);
      chk("idle_glitch_cmd",  {30'b0, pmem_read, pmem_write},  32'd0);
      tick();
    end
    pmem_resp = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
